// File: rtl/programmable_sequence_generator_fsm_pkg.sv
// Shared widths and state codes for the framed-burst sequence generator.
package programmable_sequence_generator_fsm_pkg;
  localparam int RUN_W   = 4;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_RUN  = 3'd2,
    S_TAIL = 3'd3,
    S_DONE = 3'd4
  } state_t;
endpackage

// File: rtl/hex_to_sevenseg_decoder.sv
// Hex digit to active-low seven-segment pattern, seg[6:0] = {g,f,e,d,c,b,a}.
module hex_to_sevenseg_decoder (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b1111111;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end
endmodule

// File: rtl/programmable_sequence_generator_fsm_reg_n.sv
// Run-length save register; a zero request is clamped to one so a burst is never empty.
module programmable_sequence_generator_fsm_reg_n
  import programmable_sequence_generator_fsm_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             save,
  input  logic [RUN_W-1:0] n_in,
  output logic [RUN_W-1:0] n_out
);
  always_ff @(posedge clock) begin
    if (reset)
      n_out <= RUN_W'(1);
    else if (save)
      n_out <= (n_in == '0) ? RUN_W'(1) : n_in;
  end
endmodule

// File: rtl/programmable_sequence_generator_fsm.sv
// Emits ~lvl, then run_len copies of lvl, then two ~lvl bits, optionally back to back.
module programmable_sequence_generator_fsm
  import programmable_sequence_generator_fsm_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               save,
  input  logic [RUN_W-1:0]   n_in,
  input  logic               start,
  input  logic               level,
  // "repeat" is a reserved word, hence the longer name
  input  logic               repeat_burst,
  output logic               w,
  output logic               busy,
  output logic               done,
  output logic [RUN_W-1:0]   n_out,
  output logic [STATE_W-1:0] currstate,
  output logic [STATE_W-1:0] nextstate,
  output logic [RUN_W-1:0]   count,
  output logic [6:0]         HEX0,
  output logic [6:0]         HEX2,
  output logic [9:0]         LEDR
);
  state_t           state, state_nx;
  logic [RUN_W-1:0] n_reg, run_len;
  logic             lvl;
  logic             load, cnt_en, cnt_clr;

  programmable_sequence_generator_fsm_reg_n u_reg_n (
    .clock (clock),
    .reset (reset),
    .save  (save),
    .n_in  (n_in),
    .n_out (n_reg)
  );

  always_comb begin
    state_nx = S_IDLE;
    load     = 1'b0;
    cnt_en   = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        state_nx = S_PRE;
        load     = 1'b1;
      end
      S_PRE:  state_nx = S_RUN;
      S_RUN: begin
        if (count == run_len - 1'b1) begin
          state_nx = S_TAIL;
        end else begin
          state_nx = S_RUN;
          cnt_en   = 1'b1;
        end
      end
      S_TAIL: state_nx = S_DONE;
      S_DONE: state_nx = repeat_burst ? S_PRE : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // count is only non-zero inside RUN, so every other cycle clears it
  assign cnt_clr = ~cnt_en;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clock) begin
    if (reset || cnt_clr) count <= '0;
    else if (cnt_en)      count <= count + 1'b1;
  end

  // Burst parameters are frozen at start so mid-burst save/level changes are harmless
  always_ff @(posedge clock) begin
    if (reset) begin
      run_len <= RUN_W'(1);
      lvl     <= 1'b0;
    end else if (load) begin
      run_len <= n_reg;
      lvl     <= level;
    end
  end

  always_comb begin
    case (state)
      S_PRE, S_TAIL, S_DONE: w = ~lvl;
      S_RUN:                 w = lvl;
      default:               w = 1'b0;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign n_out     = n_reg;
  assign currstate = state;
  assign nextstate = state_nx;
  assign LEDR      = {done, 7'b0, busy, w};

  hex_to_sevenseg_decoder u_hex0 (.hex({1'b0, state}), .seg(HEX0));
  hex_to_sevenseg_decoder u_hex2 (.hex(count),         .seg(HEX2));
endmodule

// File: tb/tb_programmable_sequence_generator_fsm.sv
// Random and directed stimulus checked against a queue-of-expected-cycles model of the burst format.
module tb_programmable_sequence_generator_fsm;
  logic       clock = 1'b0;
  logic       reset, save, start, level, repeat_burst;
  logic [3:0] n_in;
  logic       w, busy, done;
  logic [3:0] n_out, count;
  logic [2:0] currstate, nextstate;
  logic [6:0] HEX0, HEX2;
  logic [9:0] LEDR;

  programmable_sequence_generator_fsm dut (
    .clock(clock), .reset(reset), .save(save), .n_in(n_in), .start(start),
    .level(level), .repeat_burst(repeat_burst), .w(w), .busy(busy), .done(done),
    .n_out(n_out), .currstate(currstate), .nextstate(nextstate), .count(count),
    .HEX0(HEX0), .HEX2(HEX2), .LEDR(LEDR)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  // Model: one queue entry per future cycle of the burst; empty queue means idle.
  typedef struct { logic w; logic dn; logic [2:0] st; logic [3:0] cnt; } exp_t;
  exp_t q[$];
  logic [3:0] m_n = 4'd1, m_rl = 4'd1;
  logic       m_lvl = 1'b0;
  bit         m_idle, m_was_done;

  function automatic void push_burst();
    exp_t e;
    e = '{w: ~m_lvl, dn: 1'b0, st: 3'd1, cnt: 4'd0};
    q.push_back(e);
    for (int i = 0; i < int'(m_rl); i++) begin
      e = '{w: m_lvl, dn: 1'b0, st: 3'd2, cnt: 4'(i)};
      q.push_back(e);
    end
    e = '{w: ~m_lvl, dn: 1'b0, st: 3'd3, cnt: 4'd0};
    q.push_back(e);
    e = '{w: ~m_lvl, dn: 1'b1, st: 3'd4, cnt: 4'd0};
    q.push_back(e);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      m_n = 4'd1; m_rl = 4'd1; m_lvl = 1'b0;
    end else begin
      m_idle     = (q.size() == 0);
      m_was_done = !m_idle && q[0].dn;
      if (!m_idle) void'(q.pop_front());
      if (m_idle && start) begin
        m_rl = m_n; m_lvl = level; push_burst();
      end else if (m_was_done && repeat_burst) begin
        push_burst();
      end
      if (save) m_n = (n_in == 4'd0) ? 4'd1 : n_in;
    end
  end

  logic       e_w, e_b, e_d;
  logic [2:0] e_st;
  logic [3:0] e_cnt;
  always @(negedge clock) begin
    if (chk_en) begin
      if (q.size() == 0) begin
        e_w = 0; e_b = 0; e_d = 0; e_st = 0; e_cnt = 0;
      end else begin
        e_w = q[0].w; e_b = 1; e_d = q[0].dn; e_st = q[0].st; e_cnt = q[0].cnt;
      end
      chk("w", 16'(w), 16'(e_w));
      chk("busy", 16'(busy), 16'(e_b));
      chk("done", 16'(done), 16'(e_d));
      chk("currstate", 16'(currstate), 16'(e_st));
      chk("count", 16'(count), 16'(e_cnt));
      chk("n_out", 16'(n_out), 16'(m_n));
      chk("LEDR", 16'(LEDR), 16'({e_d, 7'b0, e_b, e_w}));
      chk("HEX0", 16'(HEX0), 16'(seg7({1'b0, e_st})));
      chk("HEX2", 16'(HEX2), 16'(seg7(e_cnt)));
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  logic [31:0] wv, dv;
  int pat [6] = '{0, 1, 1, 1, 0, 0};
  bit seen_idle;

  initial begin
    reset = 1; save = 0; start = 0; level = 0; repeat_burst = 0; n_in = 0;
    tick(); chk_en = 1;
    tick(); reset = 0;
    repeat (3) tick();
    chk("rst_w", 16'(w), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_n_out", 16'(n_out), 16'd1);
    chk("rst_hex0", 16'(HEX0), 16'h40);
    chk("rst_ledr", 16'(LEDR), 16'd0);

    // n=4, level=1
    save = 1; n_in = 4; tick(); save = 0;
    start = 1; level = 1; tick(); start = 0;
    wv = 0; dv = 0;
    for (int i = 0; i < 7; i++) begin wv[i] = w; dv[i] = done; tick(); end
    chk("b4_w", 16'(wv[6:0]), 16'h1E);
    chk("b4_done", 16'(dv[6:0]), 16'h40);
    chk("b4_idle_w", 16'(w), 16'd0);
    chk("b4_idle_busy", 16'(busy), 16'd0);

    // n_in=0 clamps to 1, level=0
    save = 1; n_in = 0; tick(); save = 0;
    chk("clamp_n_out", 16'(n_out), 16'd1);
    start = 1; level = 0; tick(); start = 0;
    wv = 0; dv = 0;
    for (int i = 0; i < 4; i++) begin wv[i] = w; dv[i] = done; tick(); end
    chk("b1_w", 16'(wv[3:0]), 16'hD);
    chk("b1_done", 16'(dv[3:0]), 16'h8);

    // n=3 repeated bursts, period 6
    save = 1; n_in = 3; tick(); save = 0;
    start = 1; level = 1; repeat_burst = 1; tick(); start = 0;
    for (int i = 0; i < 18; i++) begin
      chk("rep_w", 16'(w), 16'(pat[i % 6]));
      chk("rep_done", 16'(done), 16'((i % 6) == 5));
      tick();
    end
    repeat_burst = 0;
    seen_idle = 0;
    for (int i = 0; i < 20 && !seen_idle; i++) begin
      if (!busy) seen_idle = 1; else tick();
    end
    chk("rep_stop_timeout", 16'(seen_idle), 16'd1);

    // n=5 with save/start applied mid-RUN
    save = 1; n_in = 5; tick(); save = 0;
    start = 1; level = 1; tick(); start = 0;
    wv = 0;
    for (int i = 0; i < 8; i++) begin
      wv[i] = w;
      if (i == 2) begin save = 1; n_in = 9; start = 1; end
      else if (i == 3) begin save = 0; start = 0; end
      tick();
    end
    chk("b5_w", 16'(wv[7:0]), 16'h3E);
    chk("b5_no_restart", 16'(busy), 16'd0);
    tick(); tick();
    chk("b5_still_idle", 16'(busy), 16'd0);
    chk("b5_n_out", 16'(n_out), 16'd9);

    // reset in RUN at count 2
    save = 1; n_in = 5; tick(); save = 0;
    start = 1; level = 1; tick(); start = 0;
    tick(); tick(); tick();
    chk("mid_count2", 16'(count), 16'd2);
    reset = 1; tick(); reset = 0;
    chk("mid_state", 16'(currstate), 16'd0);
    chk("mid_count", 16'(count), 16'd0);
    chk("mid_w", 16'(w), 16'd0);
    for (int i = 0; i < 6; i++) begin chk("mid_no_done", 16'(done), 16'd0); tick(); end

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset        = ($urandom_range(0, 63) == 0);
      save         = ($urandom_range(0, 3) == 0);
      n_in         = 4'($urandom_range(0, 15));
      start        = ($urandom_range(0, 2) == 0);
      level        = 1'($urandom_range(0, 1));
      repeat_burst = ($urandom_range(0, 3) == 0);
      tick();
    end
    reset = 0; save = 0; start = 0; repeat_burst = 0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
